instr_fetch32: RTL
==================

// Module: instr_fetch32
// PURPOSE
// - Instruction-fetch stage of the MIPS32 core; the direct upstream feeder of control32.
// - Holds the PC and reads a synchronous instruction ROM.
// - Presents Instruction so control32 can decode Opcode = [31:26] and Function_opcode = [5:0].
// - Resolves next PC from control32 jump/branch outputs, ALU Zero/Addr_result and rs, and produces the jal link address.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded by reset.
// - IMEM_AW   14             Instruction ROM word-address width.
// PORTS
// - clock             in   1        Single core clock; all state updates on the posedge.
// - reset             in   1        Synchronous, active-high.
// - stall             in   1        Hold the current instruction in EXEC (IO wait).
// - Jr                in   1        From control32.
// - Jmp               in   1        From control32.
// - Jal               in   1        From control32.
// - Branch            in   1        From control32.
// - nBranch           in   1        From control32.
// - Zero              in   1        From ALU: rs == rt.
// - Addr_result       in   32       From ALU: branch target.
// - Read_data_1       in   32       From decoder: rs value, used by jr.
// - imem_en           out  1        ROM read enable.
// - imem_addr         out  IMEM_AW  ROM word address = pc[IMEM_AW+1:2].
// - imem_rdata        in   32       ROM data; valid the cycle after an enabled read; held while imem_en = 0.
// - Instruction       out  32       imem_rdata pass-through; meaningful only while instr_valid = 1.
// - instr_valid       out  1        High in the EXEC state.
// - pc                out  32       Current PC.
// - branch_base_addr  out  32       pc + 4, for the ALU branch adder.
// - link_addr         out  32       Registered return address for jal.
// BEHAVIOUR
// - Reset (any state, any cycle):
//   - pc = RESET_PC, link_addr = 0, state = FETCH.
//   - instr_valid = 0, imem_en = 0 during the reset cycle.
// - FSM states: FETCH, EXEC.
//   - Every non-stalled instruction takes exactly 2 cycles.
// - FETCH:
//   - imem_en = 1, instr_valid = 0.
//   - Next posedge: state goes to EXEC; pc unchanged.
//   - stall is ignored in FETCH.
// - EXEC:
//   - imem_en = 0, so ROM data stays stable; instr_valid = 1; Instruction = imem_rdata.
//   - Control inputs are sampled only in EXEC.
//   - stall = 1: stay in EXEC; pc and link_addr hold.
//   - stall = 0: at the posedge, pc <= npc, state goes to FETCH, and link_addr <= pc + 4 if Jal.
// - npc priority, highest first:
//   1. Jr -> {Read_data_1[31:2], 2'b00}. Misaligned jr is silently word-aligned.
//   2. Jmp | Jal -> {pc_plus4[31:28], Instruction[25:0], 2'b00}.
//   3. (Branch & Zero) | (nBranch & ~Zero) -> Addr_result.
//   4. Otherwise -> pc + 4.
//   - Simultaneous asserted controls resolve by this order; no error is flagged.
// - Arithmetic and width:
//   - pc + 4 is mod 2^32, so 0xFFFF_FFFC wraps to 0.
//   - imem_addr ignores pc bits above IMEM_AW+1 (aliasing); pc[1:0] is always 0.
// - branch_base_addr is combinational pc + 4 and valid in both states.
// - Outputs never go X after reset.
// STRUCTURE
// - Shared header mips32_defs.vh holds:
//   - FSM state encodings (FETCH = 1'b0, EXEC = 1'b1);
//   - default RESET_PC;
//   - instruction field bit ranges: OPCODE [31:26], FUNCT [5:0], JTARGET [25:0].
// - One combinational sub-module, npc_select, holds the priority mux above.
// - The PC, link and FSM registers stay in instr_fetch32.
// TESTING (behavioural ROM model, 1-cycle read latency)
// - Reset for 2 cycles, then release:
//   - pc = 0, imem_addr = 0, imem_en = 1, instr_valid = 0.
//   - instr_valid = 1 on the next cycle.
// - Three plain add instructions with no control asserted:
//   - pc steps 0 -> 4 -> 8, one step per 2 cycles.
//   - branch_base_addr tracks pc + 4.
// - beq at pc = 0x8 with Branch = 1, Zero = 1, Addr_result = 0x40 -> pc = 0x40.
// - Same with Zero = 0 -> pc = 0xC.
// - bne at pc = 0x8 with nBranch = 1, Zero = 1 -> pc = 0xC (branch not taken).
// - jal at pc = 0x8, Instruction = 0x0C00_0010, Jal = 1 -> pc = 0x40, link_addr = 0xC.
// - Jr = 1 together with Jmp = 1, Read_data_1 = 0x23 -> pc = 0x20 (Jr wins, aligned).
// - stall = 1 for 3 EXEC cycles:
//   - pc, Instruction and instr_valid hold, imem_en = 0.
//   - Releasing stall advances pc on the next posedge.
// - reset asserted mid-EXEC with stall = 1 -> next cycle pc = 0, state FETCH, link_addr = 0.

Source files
------------

// File: rtl/instr_fetch32_pkg.sv
// Shared definitions for the MIPS32 instruction-fetch slice.
//   - fetch FSM state encoding (FETCH = 0, EXEC = 1)
//   - default reset PC
//   - instruction field bit ranges (opcode, funct, jump target)
//   - flow-control bundle coming from control32
//   - jump target helper
package instr_fetch32_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Instruction field ranges decoded downstream by control32.
  localparam int OPCODE_HI  = 31;
  localparam int OPCODE_LO  = 26;
  localparam int FUNCT_HI   = 5;
  localparam int FUNCT_LO   = 0;
  localparam int JTARGET_HI = 25;
  localparam int JTARGET_LO = 0;
  localparam int JTARGET_W  = JTARGET_HI - JTARGET_LO + 1;

  // Flow-control strobes from control32.
  typedef struct packed {
    logic jr;
    logic jmp;
    logic jal;
    logic branch;
    logic nbranch;
  } flow_ctrl_t;

  // j/jal target: the 256 MB region of the delay-slot PC plus the word index.
  function automatic logic [31:0] jump_target(input logic [31:0]          pc_plus4,
                                              input logic [JTARGET_W-1:0] jtarget);
    return {pc_plus4[31:28], jtarget, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch32_npc_select.sv
// npc_select: combinational next-PC priority mux.
//   ctrl        in  flow-control strobes from control32
//   zero        in  ALU rs == rt
//   pc_plus4    in  sequential next PC
//   jtarget     in  Instruction[25:0]
//   addr_result in  ALU branch target
//   rs_val      in  rs value for jr
//   npc         out selected next PC
// Priority: jr > j/jal > taken branch > pc + 4. Conflicting strobes are
// resolved by this order silently.
import instr_fetch32_pkg::*;

module npc_select (
  input  flow_ctrl_t            ctrl,
  input  logic                  zero,
  input  logic [31:0]           pc_plus4,
  input  logic [JTARGET_W-1:0]  jtarget,
  input  logic [31:0]           addr_result,
  input  logic [31:0]           rs_val,
  output logic [31:0]           npc
);

  logic br_taken;

  assign br_taken = (ctrl.branch & zero) | (ctrl.nbranch & ~zero);

  always_comb begin
    npc = pc_plus4;
    if (ctrl.jr)
      npc = rs_val & 32'hFFFF_FFFC;   // misaligned jr is forced onto a word boundary
    else if (ctrl.jmp | ctrl.jal)
      npc = jump_target(pc_plus4, jtarget);
    else if (br_taken)
      npc = addr_result;
  end

endmodule

// File: rtl/instr_fetch32.sv
// instr_fetch32: MIPS32 instruction-fetch stage feeding control32.
//   clock, reset              core clock, synchronous active-high reset
//   stall                     hold the current instruction in EXEC
//   Jr/Jmp/Jal/Branch/nBranch flow control from control32
//   Zero, Addr_result         ALU compare result and branch target
//   Read_data_1               rs value for jr
//   imem_en/imem_addr         synchronous ROM read port (word address)
//   imem_rdata                ROM data, valid the cycle after an enabled read
//   Instruction, instr_valid  current instruction, valid in EXEC
//   pc, branch_base_addr      current PC and pc + 4
//   link_addr                 registered jal return address
// Every unstalled instruction takes two cycles: FETCH issues the ROM read,
// EXEC presents the word and commits the next PC.
import instr_fetch32_pkg::*;

module instr_fetch32 #(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               Jr,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Zero,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        Read_data_1,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Instruction,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        branch_base_addr,
  output logic [31:0]        link_addr
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_plus4;
  logic [31:0]  npc;
  logic         advance;
  flow_ctrl_t   ctrl;

  assign pc_plus4         = pc + 32'd4;   // wraps mod 2^32
  assign branch_base_addr = pc_plus4;
  assign Instruction      = imem_rdata;   // ROM holds its output while imem_en = 0
  assign imem_addr        = pc[IMEM_AW+1:2];
  assign advance          = (state == EXEC) && !stall;

  assign ctrl = '{jr: Jr, jmp: Jmp, jal: Jal, branch: Branch, nbranch: nBranch};

  npc_select u_npc (
    .ctrl        (ctrl),
    .zero        (Zero),
    .pc_plus4    (pc_plus4),
    .jtarget     (imem_rdata[JTARGET_HI:JTARGET_LO]),
    .addr_result (Addr_result),
    .rs_val      (Read_data_1),
    .npc         (npc)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; stall only matters in EXEC.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = stall ? EXEC : FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs; reset masks the read strobe and valid in the reset cycle itself.
  always_comb begin
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    if (!reset) begin
      imem_en     = (state == FETCH);
      instr_valid = (state == EXEC);
    end
  end

  // PC and link registers: control inputs only take effect on the EXEC exit edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      link_addr <= 32'h0;
    end else if (advance) begin
      pc <= npc;
      if (Jal) link_addr <= pc_plus4;
    end
  end

endmodule
